// File: rtl/io_intr_ctrl.sv
// Interrupt controller ahead of the MCU: synchronises and edge-detects request lines,
// latches them into a pending register gated by a mask, and pulses INTERRUPT until acknowledged.
module io_intr_ctrl #(
  parameter int         N_SRC     = 8,
  parameter int         PULSE_CYC = 2,
  parameter logic [7:0] ID_PEND   = 8'h20,
  parameter logic [7:0] ID_MASK   = 8'h21,
  parameter logic [7:0] ID_ACK    = 8'h22
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] SRC,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       IN_DATA,
  output logic             INTERRUPT
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  logic [N_SRC-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [N_SRC-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [N_SRC-1:0] edge_det, clr;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             int_q, int_d;
  logic             wr_pend, wr_mask, wr_ack, req;

  // MCU bus: a write is committed on the CLK edge where IO_STRB=1; there is no backpressure.
  assign wr_pend = IO_STRB && (PORT_ID == ID_PEND);
  assign wr_mask = IO_STRB && (PORT_ID == ID_MASK);
  assign wr_ack  = IO_STRB && (PORT_ID == ID_ACK);

  assign edge_det = s2_q & ~s3_q;
  assign clr      = wr_pend ? OUT_PORT[N_SRC-1:0] : '0;
  assign req      = |(pend_q & mask_q);

  always_comb begin
    s1_d   = SRC;
    s2_d   = s1_q;
    s3_d   = s2_q;
    // A fresh edge beats a simultaneous write-1-to-clear on the same bit.
    pend_d = edge_det | (pend_q & ~clr);
    mask_d = wr_mask ? OUT_PORT[N_SRC-1:0] : mask_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ASSERT;
          cnt_d   = CW'(PULSE_CYC - 1);
        end
      end
      ASSERT: begin
        if (wr_ack) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = WAIT_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_ACK: begin
        if (wr_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    int_d = (state_d == ASSERT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      int_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      int_q   <= int_d;
    end
  end

  assign INTERRUPT = int_q;

  always_comb begin
    IN_DATA = 8'h00;
    if (PORT_ID == ID_PEND) begin
      IN_DATA[N_SRC-1:0] = pend_q;
    end else if (PORT_ID == ID_MASK) begin
      IN_DATA[N_SRC-1:0] = mask_q;
    end else if (PORT_ID == ID_ACK) begin
      IN_DATA = {6'b0, state_q};
    end
  end

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Directed bench for io_intr_ctrl: a register-access vector table plus hand-written
// sequences for edge timing, masking, W1C collisions, re-fire and reset mid-pulse.
module tb_io_intr_ctrl;

  localparam logic [7:0] ID_PEND = 8'h20;
  localparam logic [7:0] ID_MASK = 8'h21;
  localparam logic [7:0] ID_ACK  = 8'h22;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] SRC = 8'h00;
  logic [7:0] PORT_ID = 8'h00;
  logic [7:0] OUT_PORT = 8'h00;
  logic       IO_STRB = 1'b0;
  logic [7:0] IN_DATA;
  logic       INTERRUPT;

  int n_total = 0;
  int n_pass  = 0;
  int c;

  io_intr_ctrl dut (
    .CLK(CLK), .RESET(RESET), .SRC(SRC), .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .IN_DATA(IN_DATA), .INTERRUPT(INTERRUPT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       strb;
    logic [7:0] id;
    logic [7:0] data;
    logic [7:0] rd_id;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] id, input logic [7:0] exp);
    IO_STRB = 1'b0;
    PORT_ID = id;
    #1;
    check(name, IN_DATA, exp);
  endtask

  task automatic count_high(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (INTERRUPT) cnt++;
    end
  endtask

  task automatic pulse_src(input logic [7:0] bits);
    SRC = bits;
    repeat (4) tick();
    SRC = 8'h00;
    repeat (4) tick();
  endtask

  initial begin
    // Reset held two cycles.
    RESET = 1'b1;
    repeat (2) tick();
    check("reset_int", {7'b0, INTERRUPT}, 8'h00);
    rd_chk("reset_pend", ID_PEND, 8'h00);
    rd_chk("reset_mask", ID_MASK, 8'h00);
    rd_chk("reset_state", ID_ACK, 8'h00);
    RESET = 1'b0;
    tick();

    // Register access table (PEND stays 0, so nothing fires).
    vecs[0] = '{1'b1, ID_MASK, 8'hA5, ID_MASK, 8'hA5};
    vecs[1] = '{1'b1, 8'h23,   8'hFF, ID_MASK, 8'hA5};
    vecs[2] = '{1'b0, ID_MASK, 8'h00, ID_PEND, 8'h00};
    vecs[3] = '{1'b1, ID_MASK, 8'h5A, ID_MASK, 8'h5A};
    vecs[4] = '{1'b0, ID_MASK, 8'h00, ID_MASK, 8'h5A};
    vecs[5] = '{1'b0, 8'h00,   8'h00, 8'h23,   8'h00};
    vecs[6] = '{1'b0, 8'h00,   8'h00, ID_ACK,  8'h00};
    vecs[7] = '{1'b1, ID_PEND, 8'hFF, ID_PEND, 8'h00};
    vecs[8] = '{1'b1, ID_ACK,  8'h00, ID_ACK,  8'h00};
    vecs[9] = '{1'b1, ID_MASK, 8'h00, ID_MASK, 8'h00};
    for (int i = 0; i < 10; i++) begin
      PORT_ID  = vecs[i].id;
      OUT_PORT = vecs[i].data;
      IO_STRB  = vecs[i].strb;
      tick();
      IO_STRB  = 1'b0;
      rd_chk($sformatf("table[%0d]", i), vecs[i].rd_id, vecs[i].exp);
    end
    check("table_int", {7'b0, INTERRUPT}, 8'h00);

    // Basic fire: SRC[0] rises before edge t.
    wr(ID_MASK, 8'h01);
    SRC = 8'h01;
    tick();             // edge t
    tick();             // edge t+1
    rd_chk("fire_pend_early", ID_PEND, 8'h00);
    c = 0;
    tick();             // edge t+2
    if (INTERRUPT) c++;
    tick();             // edge t+3
    if (INTERRUPT) c++;
    rd_chk("fire_pend_t3", ID_PEND, 8'h01);
    SRC = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (INTERRUPT) c++;
    end
    check("fire_width", 8'(c), 8'd2);
    rd_chk("fire_state_wait", ID_ACK, 8'h02);
    wr(ID_PEND, 8'h01);
    wr(ID_ACK, 8'h00);
    tick();
    check("fire_idle_int", {7'b0, INTERRUPT}, 8'h00);
    rd_chk("fire_idle_state", ID_ACK, 8'h00);

    // Masked source, then unmask.
    wr(ID_MASK, 8'h00);
    SRC = 8'h08;
    count_high(6, c);
    SRC = 8'h00;
    repeat (4) tick();
    check("masked_no_int", 8'(c), 8'd0);
    rd_chk("masked_pend", ID_PEND, 8'h08);
    wr(ID_MASK, 8'h08);  // edge w
    check("unmask_int_w", {7'b0, INTERRUPT}, 8'h00);
    tick();
    tick();              // edge w+2
    check("unmask_int_w2", {7'b0, INTERRUPT}, 8'h01);
    repeat (4) tick();
    wr(ID_PEND, 8'h08);
    wr(ID_ACK, 8'h00);
    tick();
    rd_chk("unmask_idle", ID_ACK, 8'h00);

    // W1C collision: SRC[2] edge seen on the same edge as a clear of bit 2.
    wr(ID_MASK, 8'h00);
    pulse_src(8'h05);
    rd_chk("w1c_setup", ID_PEND, 8'h05);
    SRC = 8'h04;
    tick();
    tick();
    wr(ID_PEND, 8'h04);
    rd_chk("w1c_collision", ID_PEND, 8'h05);
    wr(ID_PEND, 8'h04);
    rd_chk("w1c_plain", ID_PEND, 8'h01);
    SRC = 8'h00;
    repeat (4) tick();

    // Re-fire after ack with a partial clear.
    pulse_src(8'h02);
    rd_chk("refire_setup", ID_PEND, 8'h03);
    wr(ID_MASK, 8'hFF);
    repeat (4) tick();
    rd_chk("refire_wait", ID_ACK, 8'h02);
    wr(ID_PEND, 8'h01);
    rd_chk("refire_pend", ID_PEND, 8'h02);
    wr(ID_ACK, 8'h00);   // edge a
    check("refire_gap", {7'b0, INTERRUPT}, 8'h00);
    tick();
    check("refire_rise", {7'b0, INTERRUPT}, 8'h01);
    count_high(5, c);
    check("refire_width", 8'(c), 8'd1);
    rd_chk("refire_state", ID_ACK, 8'h02);

    // Ack during ASSERT cuts the pulse short.
    wr(ID_ACK, 8'h00);
    tick();
    check("cut_rise", {7'b0, INTERRUPT}, 8'h01);
    wr(ID_ACK, 8'h00);
    check("cut_drop", {7'b0, INTERRUPT}, 8'h00);
    rd_chk("cut_state", ID_ACK, 8'h00);

    // Reset mid-pulse (req still pending, so ASSERT re-enters).
    tick();
    check("rst_pre_int", {7'b0, INTERRUPT}, 8'h01);
    RESET = 1'b1;
    tick();
    check("rst_int", {7'b0, INTERRUPT}, 8'h00);
    rd_chk("rst_pend", ID_PEND, 8'h00);
    rd_chk("rst_mask", ID_MASK, 8'h00);
    rd_chk("rst_state", ID_ACK, 8'h00);
    RESET = 1'b0;
    repeat (3) tick();
    check("rst_stay_low", {7'b0, INTERRUPT}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
